mcp_scan: RTL and testbench



---
 rtl/mcp_scan_pkg.sv | 38 +++
 rtl/mcp_sclk_gen.sv | 33 +++
 rtl/mcp_scan.sv | 129 ++++++++++++
 tb/tb_mcp_scan.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp_scan_pkg.sv
// Shared types and constants for the MCP3xxx round-robin scanner.
// Hysteresis on the alarm flags is enabled by defining MCP_SCAN_HYST_EN.
package mcp_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } state_t;

  localparam logic CMD_START = 1'b1;
  localparam logic CMD_SGL   = 1'b1;

  // start, sgl, d2, d1, d0, sample, null
  localparam int HDR_EDGES = 7;

  // cs-high time between frames, in sclk half-periods
  localparam int GAP_HALVES = 3;

  function automatic logic cmd_bit(
    input logic [4:0] k,
    input logic [2:0] ch
  );
    logic b;
    b = 1'b0;
    unique case (k)
      5'd1:    b = CMD_START;
      5'd2:    b = CMD_SGL;
      5'd3:    b = ch[2];
      5'd4:    b = ch[1];
      5'd5:    b = ch[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mcp_sclk_gen.sv
// SPI mode-0 clock generator: CLK_DIV cycles per half-period.
// Counter and sclk are held cleared whenever run is low.
module mcp_sclk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          term;

  assign term      = run && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = term && !sclk;
  assign fall_tick = term && sclk;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= term ? '0 : cnt + CW'(1);
      if (term) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/mcp_scan.sv
// Round-robin single-ended scanner for MCP3004/3008/3204/3208 ADCs.
// Define MCP_SCAN_HYST_EN to add hysteresis to the over-threshold flags.
module mcp_scan
  import mcp_scan_pkg::*;
#(
  parameter int                  NCH      = 8,
  parameter int                  RES_BITS = 10,
  parameter int                  CLK_DIV  = 25,
  parameter logic [RES_BITS-1:0] THRESH   = RES_BITS'(512),
  parameter int                  HYST     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                cs,
  output logic                sclk,
  output logic                din,
  input  logic                dout,
  output logic                sample_valid,
  output logic [2:0]          sample_ch,
  output logic [RES_BITS-1:0] sample_data,
  output logic [NCH-1:0]      over,
  output logic                r,
  output logic                g
);

  localparam int E       = HDR_EDGES + RES_BITS;
  localparam int EW      = 5;
  localparam int GAP_LEN = GAP_HALVES * CLK_DIV;
  localparam int GW      = $clog2(GAP_LEN + 1);

`ifdef MCP_SCAN_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  localparam int LO_I = (int'(THRESH) > HYST) ? int'(THRESH) - HYST : 0;
  localparam logic [RES_BITS-1:0] LO = RES_BITS'(LO_I);

  state_t              state, nxt;
  logic [EW-1:0]       ecnt;
  logic [GW-1:0]       gcnt;
  logic [2:0]          ptr;
  logic [RES_BITS-1:0] shreg;
  logic                run;
  logic                rise_tick;
  logic                fall_tick;
  logic                frame_end;
  logic                gap_done;
  logic                hit;
  logic                clr;

  assign run       = (state == SETUP) || (state == SHIFT);
  assign cs        = ~run;
  assign frame_end = (state == SHIFT) && fall_tick && (ecnt == EW'(E));
  assign gap_done  = (state == GAP) && (gcnt == GW'(GAP_LEN - 1));

  assign hit = sample_data >= THRESH;
  assign clr = HYST_ON ? (sample_data < LO) : !hit;

  assign r = |over;
  assign g = ~r;

  mcp_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .sclk     (sclk),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (en) nxt = SETUP;
      SETUP:   if (rise_tick) nxt = SHIFT;
      SHIFT:   if (frame_end) nxt = GAP;
      GAP:     if (gap_done) nxt = en ? SETUP : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ecnt         <= '0;
      gcnt         <= '0;
      ptr          <= '0;
      shreg        <= '0;
      din          <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      over         <= '0;
    end else begin
      state        <= nxt;
      sample_valid <= frame_end;

      if (!run)           ecnt <= '0;
      else if (rise_tick) ecnt <= ecnt + EW'(1);

      gcnt <= (state == GAP) ? gcnt + GW'(1) : '0;

      // bit 1 goes out with cs; the rest change on sclk falls
      if (nxt == SETUP && state != SETUP)
        din <= CMD_START;
      else if (fall_tick)
        din <= cmd_bit(ecnt + EW'(1), ptr);

      if (rise_tick && ecnt >= EW'(HDR_EDGES))
        shreg <= {shreg[RES_BITS-2:0], dout};

      if (frame_end) begin
        sample_data <= shreg;
        sample_ch   <= ptr;
        ptr         <= (ptr == 3'(NCH - 1)) ? 3'd0 : ptr + 3'd1;
      end

      for (int i = 0; i < NCH; i++)
        if (sample_valid && sample_ch == 3'(i))
          over[i] <= hit | (over[i] & ~clr);
    end
  end

endmodule

// File: tb/tb_mcp_scan.sv
// Directed bench for mcp_scan: 10-bit/8-channel and 12-bit/1-channel
// instances, each driven by a small behavioural ADC model.
module tb_mcp_scan;

`ifdef MCP_SCAN_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ena, csa, sclka, dina, va, ra, ga;
  logic        doa = 1'b0;
  logic [2:0]  cha;
  logic [9:0]  da;
  logic [7:0]  ova;

  logic        enb, csb, sclkb, dinb, vb, rb, gb;
  logic        dob = 1'b0;
  logic [2:0]  chb;
  logic [11:0] db;
  logic [0:0]  ovb;

  mcp_scan #(
    .NCH(8), .RES_BITS(10), .CLK_DIV(4), .THRESH(10'd512), .HYST(16)
  ) u_a (
    .clk(clk), .rst(rst), .en(ena), .cs(csa), .sclk(sclka),
    .din(dina), .dout(doa), .sample_valid(va), .sample_ch(cha),
    .sample_data(da), .over(ova), .r(ra), .g(ga)
  );

  mcp_scan #(
    .NCH(1), .RES_BITS(12), .CLK_DIV(4), .THRESH(12'd2048), .HYST(16)
  ) u_b (
    .clk(clk), .rst(rst), .en(enb), .cs(csb), .sclk(sclkb),
    .din(dinb), .dout(dob), .sample_valid(vb), .sample_ch(chb),
    .sample_data(db), .over(ovb), .r(rb), .g(gb)
  );

  // ADC models
  logic [11:0] vtab [8];
  logic [11:0] vbval;
  int          ea = 0;
  int          eb = 0;
  logic [4:0]  cmda = '0;
  logic [4:0]  cmdb = '0;

  always @(negedge csa) ea = 0;
  always @(posedge sclka) begin
    ea++;
    if (ea <= 5) cmda[5-ea] = dina;
  end
  always @(negedge sclka) begin
    if (ea >= 7 && ea < 17) doa = vtab[cmda[2:0]][16-ea];
    else doa = 1'b0;
  end

  always @(negedge csb) eb = 0;
  always @(posedge sclkb) begin
    eb++;
    if (eb <= 5) cmdb[5-eb] = dinb;
  end
  always @(negedge sclkb) begin
    if (eb >= 7 && eb < 19) dob = vbval[18-eb];
    else dob = 1'b0;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   fa = 0, fb = 0, nva = 0, nvb = 0;
  logic pcsa = 1'b1, pcsb = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    if (pcsa && !csa) fa = cyc;
    if (pcsb && !csb) fb = cyc;
    pcsa = csa;
    pcsb = csb;
    if (va) nva++;
    if (vb) nvb++;
  endtask

  task automatic wait_va(input int ch);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (va && (ch < 0 || int'(cha) == ch)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("wait_valid_a");
  endtask

  task automatic wait_vb();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (vb) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("wait_valid_b");
  endtask

  task automatic wait_fall_a();
    int f0;
    f0 = fa;
    for (int i = 0; i < 500; i++) begin
      if (fa != f0) return;
      tick();
    end
    if (fa == f0) timeout("wait_cs_fall_a");
  endtask

  task automatic wait_edge_a(input int k);
    for (int i = 0; i < 500; i++) begin
      if (ea == k && !csa) return;
      tick();
    end
    timeout("wait_sclk_edge_a");
  endtask

  typedef struct {
    logic [9:0] d;
    logic [7:0] ov_nh;
    logic [7:0] ov_h;
  } vec_t;

  vec_t tab [10];

  initial begin
    int         f0, chd;
    logic [7:0] ov, prev_ov;

    tab[0] = '{10'd600,  8'h01, 8'h01};
    tab[1] = '{10'd400,  8'h00, 8'h00};
    tab[2] = '{10'd520,  8'h01, 8'h01};
    tab[3] = '{10'd500,  8'h00, 8'h01};
    tab[4] = '{10'd495,  8'h00, 8'h00};
    tab[5] = '{10'd512,  8'h01, 8'h01};
    tab[6] = '{10'd511,  8'h00, 8'h01};
    tab[7] = '{10'd496,  8'h00, 8'h01};
    tab[8] = '{10'd0,    8'h00, 8'h00};
    tab[9] = '{10'd1023, 8'h01, 8'h01};

    for (int i = 0; i < 8; i++) vtab[i] = 12'd100;
    vtab[3] = 12'h2A5;
    vbval   = 12'hABC;
    rst = 1'b1;
    ena = 1'b0;
    enb = 1'b0;
    repeat (3) tick();

    chk("rst_cs", csa, 1);
    chk("rst_sclk", sclka, 0);
    chk("rst_din", dina, 0);
    chk("rst_valid", va, 0);
    chk("rst_ch", cha, 0);
    chk("rst_data", da, 0);
    chk("rst_over", ova, 0);
    chk("rst_r", ra, 0);
    chk("rst_g", ga, 1);

    rst = 1'b0;
    tick();
    ena = 1'b1;
    nva = 0;
    tick();
    chk("en_to_cs", csa, 0);

    wait_va(3);
    chk("ch3_frame_no", nva, 4);
    chk("ch3_ch", cha, 3);
    chk("ch3_data", da, 10'h2A5);
    chk("ch3_latency", cyc - fa, 136);
    chk("ch3_sclk_edges", ea, 17);
    chk("ch3_din_seq", cmda, 5'b11011);
    chk("ch3_cs_rise", csa, 1);
    tick();
    chk("valid_width", va, 0);
    f0 = fa;
    wait_fall_a();
    chk("frame_len10", fa - f0, 148);

    vtab[3] = 12'd100;
    wait_va(3);
    tick();
    prev_ov = 8'h00;
    for (int i = 0; i < 10; i++) begin
      wait_va(7);
      vtab[0] = {2'b00, tab[i].d};
      ov = HYST_ON ? tab[i].ov_h : tab[i].ov_nh;
      wait_va(0);
      chk($sformatf("v%0d_data", i), da, tab[i].d);
      chk($sformatf("v%0d_over_hold", i), ova, prev_ov);
      tick();
      chk($sformatf("v%0d_over", i), ova, ov);
      chk($sformatf("v%0d_r", i), ra, |ov);
      chk($sformatf("v%0d_g", i), ga, ~|ov);
      prev_ov = ov;
    end

    // drop en at rising edge 5 of a frame
    wait_fall_a();
    wait_edge_a(5);
    ena = 1'b0;
    chd = int'(cmda[2:0]);
    nva = 0;
    f0  = fa;
    repeat (400) tick();
    chk("endrop_valids", nva, 1);
    chk("endrop_ch", cha, chd);
    chk("endrop_no_cs_fall", fa, f0);
    chk("endrop_cs_high", csa, 1);
    ena = 1'b1;
    wait_va(-1);
    chk("reen_next_ch", cha, (chd + 1) % 8);

    // reset at rising edge 10
    vtab[0] = 12'd600;
    wait_va(0);
    tick();
    chk("prerst_over", ova, 8'h01);
    wait_va(2);
    wait_fall_a();
    wait_edge_a(10);
    rst = 1'b1;
    nva = 0;
    tick();
    chk("midrst_cs", csa, 1);
    chk("midrst_sclk", sclka, 0);
    chk("midrst_ch", cha, 0);
    chk("midrst_over", ova, 0);
    chk("midrst_din", dina, 0);
    chk("midrst_g", ga, 1);
    repeat (2) tick();
    rst = 1'b0;
    wait_va(-1);
    chk("midrst_no_valid", nva, 1);
    chk("postrst_ch", cha, 0);
    chk("postrst_data", da, 10'd600);

    // 12-bit, single channel
    enb = 1'b1;
    tick();
    chk("b_en_to_cs", csb, 0);
    wait_vb();
    chk("b_ch", chb, 0);
    chk("b_data", db, 12'hABC);
    chk("b_sclk_edges", eb, 19);
    chk("b_din_seq", cmdb, 5'b11000);
    chk("b_latency", cyc - fb, 152);
    tick();
    chk("b_over", ovb, 1);
    chk("b_r", rb, 1);
    chk("b_g", gb, 0);
    f0 = fb;
    for (int i = 0; i < 300 && fb == f0; i++) tick();
    chk("frame_len12", fb - f0, 164);
    wait_vb();
    chk("b_ch_wrap", chb, 0);
    chk("b_data2", db, 12'hABC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
